// File: rtl/uart_tx.sv
// 8E1/8N1 UART transmitter with internal baud counter.
// One byte per accepted start; tx comes straight from a flop.
module uart_tx #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int PARITY_EN    = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       start,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic par_q, par_d;
  logic tx_q, tx_d;

  logic bit_end;
  logic last_stop;

  assign bit_end   = (state_q != IDLE) && (cnt_q == CNT_MAX);
  assign last_stop = (idx_q == STOP_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = START;
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end && idx_q == 3'd7)
          state_d = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end && last_stop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: baud counter, bit index, shifter, parity
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
      if (start) begin
        shift_d = din;
        par_d   = ^din;
      end
    end else if (bit_end) begin
      cnt_d = '0;
      unique case (state_q)
        DATA: begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = (idx_q == 3'd7) ? 3'd0 : idx_q + 3'd1;
        end
        STOP: begin
          idx_d = last_stop ? 3'd0 : idx_q + 3'd1;
        end
        default: idx_d = 3'd0;
      endcase
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Datapath and line registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // Outputs: line level for the upcoming state, status from current state
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_q;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    busy = (state_q != IDLE);
    done = (state_q == STOP) && bit_end && last_stop;
  end

  assign tx = tx_q;

endmodule
